// File: rtl/ibuff_queue_pkg.sv
`default_nettype none
//============================================================================
// Module  : frontend_pkg
// Purpose : Shared frontend types and default sizing for the instruction
//           buffer (ibuff_queue) and anything that talks to it.
// Contents: IBQ_XLEN, IBQ_DEPTH, IBQ_BHR_W default constants;
//           ibq_entry_t queued entry record {instr, pc, bhr, exc}.
// Revision: 1.0 - initial release
//============================================================================
package frontend_pkg;

    localparam int IBQ_XLEN  = 32;
    localparam int IBQ_DEPTH = 8;
    localparam int IBQ_BHR_W = 10;

    // One buffered fetch result at the default configuration.
    typedef struct packed {
        logic [IBQ_XLEN-1:0]  instr;
        logic [IBQ_XLEN-1:0]  pc;
        logic [IBQ_BHR_W-1:0] bhr;
        logic                 exc;
    } ibq_entry_t;

endpackage : frontend_pkg
`default_nettype wire

// File: rtl/ibuff_queue_if.sv
`default_nettype none
//============================================================================
// Module  : ibuff_queue_if
// Purpose : Bundles the fetch-side enqueue port, decode-side dequeue port,
//           flush and status signals of the instruction buffer.
// Modports: master - fetch/decode environment (drives enq_*, deq_ready,
//                    flush; observes enq_ready, deq_*, count, stall_out)
//           slave  - the queue itself
// Revision: 1.0 - initial release
//============================================================================
interface ibuff_queue_if
    import frontend_pkg::*;
#(
    parameter int XLEN  = IBQ_XLEN,
    parameter int DEPTH = IBQ_DEPTH,
    parameter int BHR_W = IBQ_BHR_W
);
    localparam int PTR_W = $clog2(DEPTH);

    logic             flush;
    logic             enq_valid;
    logic             enq_ready;
    logic [XLEN-1:0]  enq_instr;
    logic [XLEN-1:0]  enq_pc;
    logic [BHR_W-1:0] enq_bhr;
    logic             enq_exc;
    logic             deq_valid;
    logic             deq_ready;
    logic [XLEN-1:0]  deq_instr;
    logic [XLEN-1:0]  deq_pc;
    logic [BHR_W-1:0] deq_bhr;
    logic             deq_exc;
    logic [PTR_W:0]   count;
    logic             stall_out;

    modport master (
        output flush, enq_valid, enq_instr, enq_pc, enq_bhr, enq_exc, deq_ready,
        input  enq_ready, deq_valid, deq_instr, deq_pc, deq_bhr, deq_exc,
               count, stall_out
    );

    modport slave (
        input  flush, enq_valid, enq_instr, enq_pc, enq_bhr, enq_exc, deq_ready,
        output enq_ready, deq_valid, deq_instr, deq_pc, deq_bhr, deq_exc,
               count, stall_out
    );

endinterface : ibuff_queue_if
`default_nettype wire

// File: rtl/ibuff_queue_ptr_ctrl.sv
`default_nettype none
//============================================================================
// Module  : ibq_ptr_ctrl
// Purpose : Read/write pointer control for the instruction buffer. Pointers
//           carry one extra wrap bit so full and empty are distinguishable.
//           Flush returns both pointers to zero ahead of any enq/deq.
// Ports   : clk, rst (async, active-high), flush, enq_fire, deq_fire
//           rd_idx, wr_idx - storage indices
//           full, empty, count - occupancy status (registered-state only)
// Revision: 1.0 - initial release
//============================================================================
module ibq_ptr_ctrl #(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             flush,
    input  wire logic             enq_fire,
    input  wire logic             deq_fire,
    output logic      [PTR_W-1:0] rd_idx,
    output logic      [PTR_W-1:0] wr_idx,
    output logic                  full,
    output logic                  empty,
    output logic      [PTR_W:0]   count
);

    // Wrap-bit arithmetic relies on the index field rolling over exactly at DEPTH.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("ibq_ptr_ctrl: DEPTH must be a power of two and at least 2");
    end

    localparam logic [PTR_W:0] c_PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (enq_fire) wr_ptr_d = wr_ptr_q + c_PTR_ONE;
            if (deq_fire) rd_ptr_d = rd_ptr_q + c_PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    assign rd_idx = rd_ptr_q[PTR_W-1:0];
    assign wr_idx = wr_ptr_q[PTR_W-1:0];
    assign empty  = (rd_ptr_q == wr_ptr_q);
    assign full   = (rd_ptr_q[PTR_W-1:0] == wr_ptr_q[PTR_W-1:0]) &&
                    (rd_ptr_q[PTR_W] != wr_ptr_q[PTR_W]);
    // Modulo 2^(PTR_W+1) subtraction gives occupancy across the wrap.
    assign count  = wr_ptr_q - rd_ptr_q;

endmodule : ibq_ptr_ctrl
`default_nettype wire

// File: rtl/ibuff_queue.sv
`default_nettype none
//============================================================================
// Module  : ibuff_queue
// Purpose : Instruction buffer between fetch stage 2 and decode (d1).
//           Holds {instr, pc, bhr, exc} entries in order, presents the head
//           with valid/ready, backpressures fetch when full, and empties on
//           any resteer flush.
// Ports   : clk, rst (async, active-high)
//           bus (ibuff_queue_if.slave): flush, enq_* (fetch side),
//           deq_* (decode side), count, stall_out
// Options : IBUFF_QUEUE_BYPASS_EN - when defined, an entry offered to an
//           empty queue while decode is ready passes straight through to
//           deq_* in the same cycle without being stored.
// Revision: 1.0 - initial release
//============================================================================
module ibuff_queue
    import frontend_pkg::*;
#(
    parameter int XLEN  = IBQ_XLEN,
    parameter int DEPTH = IBQ_DEPTH,
    parameter int BHR_W = IBQ_BHR_W
) (
    input  wire logic  clk,
    input  wire logic  rst,
    ibuff_queue_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0]  instr;
        logic [XLEN-1:0]  pc;
        logic [BHR_W-1:0] bhr;
        logic             exc;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    entry_t           w_enq_entry;
    entry_t           w_head;

    logic [PTR_W-1:0] w_rd_idx;
    logic [PTR_W-1:0] w_wr_idx;
    logic             w_full;
    logic             w_empty;
    logic [PTR_W:0]   w_count;
    logic             w_bypass;
    logic             w_enq_fire;
    logic             w_deq_fire;

`ifdef IBUFF_QUEUE_BYPASS_EN
    // Empty queue with a ready consumer: hand the entry over directly.
    assign w_bypass = w_empty & bus.enq_valid & bus.deq_ready & ~bus.flush;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed entry is consumed by decode, so it is never written.
    assign w_enq_fire = bus.enq_valid & ~w_full & ~bus.flush & ~w_bypass;
    assign w_deq_fire = ~w_empty & bus.deq_ready & ~bus.flush;

    ibq_ptr_ctrl #(
        .DEPTH    (DEPTH)
    ) u_ptr_ctrl (
        .clk      (clk),
        .rst      (rst),
        .flush    (bus.flush),
        .enq_fire (w_enq_fire),
        .deq_fire (w_deq_fire),
        .rd_idx   (w_rd_idx),
        .wr_idx   (w_wr_idx),
        .full     (w_full),
        .empty    (w_empty),
        .count    (w_count)
    );

    assign w_enq_entry = '{instr: bus.enq_instr, pc: bus.enq_pc,
                           bhr: bus.enq_bhr, exc: bus.enq_exc};

    always_comb begin
        mem_d = mem_q;
        if (w_enq_fire) mem_d[w_wr_idx] = w_enq_entry;
    end

    // Storage is cleared on reset so the head reads back as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign w_head = w_bypass ? w_enq_entry : mem_q[w_rd_idx];

    assign bus.deq_valid = ~w_empty | w_bypass;
    assign bus.deq_instr = w_head.instr;
    assign bus.deq_pc    = w_head.pc;
    assign bus.deq_bhr   = w_head.bhr;
    assign bus.deq_exc   = w_head.exc;
    assign bus.enq_ready = ~w_full;
    assign bus.stall_out = w_full;
    assign bus.count     = w_count;

endmodule : ibuff_queue
`default_nettype wire

// File: doc/ibuff_queue.md
Name: ibuff_queue

Overview:
- Instruction buffer between fetch stage 2 and opcode decode (d1) in the frontend.
- Captures fetched instruction words with their PC, BHR snapshot and exception flag, then presents them in order to decode with a valid/ready handshake.
- Decouples fetch from decode stalls: full asserts backpressure to fetch.
- Any resteer (BR mispredict, ROB exception, D1 resteer) flushes all contents.

Parameters:
- XLEN, 32, instruction and PC width
- DEPTH, 8, number of entries; power of two, minimum 2
- BHR_W, 10, branch history snapshot width
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridable

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  resteer; discards all entries
- enq_valid  in  1  fetch presents an entry
- enq_ready  out  1  queue can accept; equals !full
- enq_instr  in  XLEN  instruction word
- enq_pc  in  XLEN  instruction PC
- enq_bhr  in  BHR_W  predictor BHR at fetch
- enq_exc  in  1  fetch exception flag
- deq_valid  out  1  head entry valid
- deq_ready  in  1  decode accepts head
- deq_instr  out  XLEN  head instruction
- deq_pc  out  XLEN  head PC
- deq_bhr  out  BHR_W  head BHR
- deq_exc  out  1  head exception flag
- count  out  PTR_W+1  current occupancy
- stall_out  out  1  equals full; fed to fetch stall_in

Behaviour:
- Storage: circular array of DEPTH entries {instr, pc, bhr, exc}.
- Pointers: rd_ptr and wr_ptr, each PTR_W+1 bits with a wrap bit.
  - empty = pointers equal.
  - full = index bits equal and wrap bits differ.
- Enqueue fires when enq_valid && enq_ready. The entry is written at wr_ptr, and wr_ptr increments on that clock edge.
- Dequeue fires when deq_valid && deq_ready. rd_ptr increments on that edge.
- deq_valid = !empty. deq_* are driven combinationally from the array at rd_ptr.
  - Latency: an entry written at edge N is visible on deq_* after edge N.
  - Minimum fill-to-out latency is 1 cycle.
- enq_ready = !full, registered-state only. There is no combinational path from deq_ready to enq_ready.
  - When full, a simultaneous dequeue does not allow an enqueue in the same cycle.
- Empty with both valid: enqueue happens and the dequeue does not fire. deq_valid is 0, so there is no pass-through unless the optional feature is enabled.
- Simultaneous enqueue and dequeue, not empty and not full: both fire and count is unchanged.
- Wrap-around: index bits roll from DEPTH-1 to 0 and the wrap bit toggles.
- count = wr_ptr - rd_ptr, taken modulo 2^(PTR_W+1).
- Flush has priority over everything: on the edge with flush=1, rd_ptr and wr_ptr are set to 0.
  - Enqueues and dequeues in that cycle are discarded.
  - Next cycle: deq_valid=0, count=0, enq_ready=1.
- Flush while empty: no effect beyond the pointer reset.
- Reset, asynchronous, including mid-operation: pointers go to 0 immediately.
  - Outputs: deq_valid=0, enq_ready=1, stall_out=0, count=0.
  - deq_* data outputs are 0, because array entries are cleared on reset.
- exc entries are queued like any other entry. The queue does not interpret them.

Optional Feature:
- Macro: IBUFF_QUEUE_BYPASS_EN.
- Defined: when the queue is empty and enq_valid && deq_ready, the entry passes combinationally to deq_* with deq_valid=1. No write occurs and the pointers are unchanged. Flush still suppresses the bypass: deq_valid=0 while flush=1.
- Undefined: there is no bypass. Behaviour is exactly as above, with a minimum latency of 1 cycle.

Decomposition:
- Shared package frontend_pkg holds:
  - ibq_entry_t struct {instr, pc, bhr, exc}
  - default constants IBQ_DEPTH=8 and BHR_W=10
- One natural sub-module: ibq_ptr_ctrl, covering pointer increment/wrap, full/empty/count and flush priority.
- Storage and output muxing stay in the top-level block.

Test Plan:
- Reset release, then enqueue PCs 0x1000, 0x1004, 0x1008 with deq_ready=0.
  - Required: count=3, deq_pc=0x1000, deq_valid=1.
  - Then raise deq_ready: the three PCs appear in order on consecutive cycles, then deq_valid=0.
- Fill 8 entries with deq_ready=0.
  - Required: full, enq_ready=0, stall_out=1, count=8.
  - A ninth enq_valid (instr 0xDEADBEEF) is not accepted.
  - One dequeue makes enq_ready=1 on the next cycle.
- Wrap test: stream 20 entries with enq and deq both active from the steady state.
  - Required: output order matches input order, count stays 1, no loss across the pointer wrap.
- Flush with 5 entries and a simultaneous enq/deq.
  - Required: the next cycle has count=0 and deq_valid=0.
  - The next enqueue, PC 0x2000, appears at the head.
- Assert rst asynchronously between edges with 4 entries queued.
  - Required: deq_valid=0 and count=0 immediately, without a clock edge; stall_out=0.
- With IBUFF_QUEUE_BYPASS_EN, empty queue, enq_valid=1 and deq_ready=1, PC 0x3000.
  - Required: deq_pc=0x3000 in the same cycle, count remains 0.
  - Without the macro: deq_valid=0 that cycle and count=1 after the edge.
